// File: rtl/instr_exec_unit.sv
// ============================================================================
// instr_exec_unit
//
// Purpose:
//   Walks an external instruction register (entries 0..count-1), executes
//   one arithmetic operation per entry and streams the results out through a
//   valid/ready output register. The datapath is a two-register pipeline:
//     fetch  -> stage E (captured opcode/operands/index)
//     stage E -> output register (ALU evaluated on the way in)
//   A three-state control FSM (IDLE, RUN, DRAIN) sequences a run.
//
// Parameters:
//   DEPTH  : number of instruction register entries (default 32)
//   DATA_W : signed operand width (default 32); results are 2*DATA_W wide
//   IDX_W  : $clog2(DEPTH), width of entry indices
//
// Ports:
//   clk        in   rising-edge clock
//   reset_en   in   asynchronous active-low reset
//   start      in   begin a run (sampled in IDLE only)
//   count      in   entries to execute, clamped to DEPTH
//   busy       out  run in progress
//   done       out  one-cycle pulse at end of run
//   read_index out  registered read address to the instruction register
//   opcode     in   entry opcode (combinational from read_index)
//   operand_a  in   signed operand a (combinational from read_index)
//   operand_b  in   signed operand b (combinational from read_index)
//   res_valid  out  output register holds a result
//   res_ready  in   downstream accepts the result
//   res_index  out  entry index of the result
//   res_opc    out  opcode of the result
//   result     out  signed 2*DATA_W result
//   res_err    out  divide or modulo by zero
// ============================================================================
module instr_exec_unit #(
    parameter  int DEPTH  = 32,
    parameter  int DATA_W = 32,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_en,
    input  logic                  start,
    input  logic [IDX_W:0]        count,
    output logic                  busy,
    output logic                  done,
    output logic [IDX_W-1:0]      read_index,
    input  logic [2:0]            opcode,
    input  logic [DATA_W-1:0]     operand_a,
    input  logic [DATA_W-1:0]     operand_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [IDX_W-1:0]      res_index,
    output logic [2:0]            res_opc,
    output logic [2*DATA_W-1:0]   result,
    output logic                  res_err
);

    localparam int RES_W = 2 * DATA_W;

    localparam logic [IDX_W:0]   DEPTH_C  = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W:0]   ONE_C    = (IDX_W+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    typedef enum logic [2:0] {
        OP_ZERO  = 3'd0,
        OP_PASSA = 3'd1,
        OP_PASSB = 3'd2,
        OP_ADD   = 3'd3,
        OP_SUB   = 3'd4,
        OP_MULT  = 3'd5,
        OP_DIV   = 3'd6,
        OP_MOD   = 3'd7
    } opc_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t              r_state;
    logic                r_busy;
    logic                r_done;
    logic [IDX_W-1:0]    r_read_index;
    logic [IDX_W:0]      r_remaining;     // entries still to be fetched

    logic                r_e_valid;
    opc_t                r_e_opc;
    logic [DATA_W-1:0]   r_e_a;
    logic [DATA_W-1:0]   r_e_b;
    logic [IDX_W-1:0]    r_e_idx;

    logic                r_res_valid;
    logic [IDX_W-1:0]    r_res_index;
    logic [2:0]          r_res_opc;
    logic [RES_W-1:0]    r_result;
    logic                r_res_err;

    // ------------------------------------------------------------------
    // Handshake / pipeline control
    // ------------------------------------------------------------------
    logic                w_out_free;      // output register is free after this edge
    logic                w_e_adv;         // stage E moves into the output register
    logic                w_e_free;        // stage E may accept a new entry
    logic                w_fetch;         // capture the addressed entry this cycle
    logic [IDX_W:0]      w_count_clamped;
    logic [IDX_W-1:0]    w_next_index;

    assign w_out_free      = !r_res_valid || res_ready;
    assign w_e_adv         = r_e_valid && w_out_free;
    assign w_e_free        = !r_e_valid || w_out_free;
    assign w_fetch         = (r_state == ST_RUN) && w_e_free;
    assign w_count_clamped = (count > DEPTH_C) ? DEPTH_C : count;
    // Explicit wrap keeps non-power-of-two DEPTH values inside the table.
    assign w_next_index    = (r_read_index == LAST_IDX) ? '0 : r_read_index + 1'b1;

    // ------------------------------------------------------------------
    // Control FSM with registered busy/done/read_index
    // ------------------------------------------------------------------
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_en) begin
        if (!reset_en) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_read_index <= '0;
            r_remaining  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_count_clamped != '0) begin
                            r_state      <= ST_RUN;
                            r_busy       <= 1'b1;
                            r_read_index <= '0;
                            r_remaining  <= w_count_clamped;
                        end else begin
                            // Empty run: acknowledge without ever going busy.
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_fetch) begin
                        r_read_index <= w_next_index;
                        r_remaining  <= r_remaining - 1'b1;
                        if (r_remaining == ONE_C) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Leave once the pipeline is empty as of this edge, so done
                    // follows the last result without an idle gap.
                    if (!r_e_valid && w_out_free) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stage E: valid bit (reset) and payload (no reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_en) begin
        if (!reset_en) begin
            r_e_valid <= 1'b0;
        end else if (w_fetch) begin
            r_e_valid <= 1'b1;
        end else if (w_e_adv) begin
            r_e_valid <= 1'b0;
        end
    end

    // NOTE: the stage-E payload has no reset; it is only ever observed while
    // r_e_valid is set, so clearing it would add reset fanout for nothing.
    always_ff @(posedge clk) begin
        if (w_fetch) begin
            r_e_opc <= opc_t'(opcode);
            r_e_a   <= operand_a;
            r_e_b   <= operand_b;
            r_e_idx <= r_read_index;
        end
    end

    // ------------------------------------------------------------------
    // ALU on the stage-E contents
    // ------------------------------------------------------------------
    logic signed [RES_W-1:0] w_a_ext;
    logic signed [RES_W-1:0] w_b_ext;
    logic signed [RES_W-1:0] w_alu_result;
    logic                    w_alu_err;

    assign w_a_ext = {{DATA_W{r_e_a[DATA_W-1]}}, r_e_a};
    assign w_b_ext = {{DATA_W{r_e_b[DATA_W-1]}}, r_e_b};

    // NOTE: defaults at the top of the block give every output a value on
    // every path, so no latch is inferred.
    always_comb begin
        w_alu_result = '0;
        w_alu_err    = 1'b0;
        case (r_e_opc)
            OP_ZERO:  w_alu_result = '0;
            OP_PASSA: w_alu_result = w_a_ext;
            OP_PASSB: w_alu_result = w_b_ext;
            OP_ADD:   w_alu_result = w_a_ext + w_b_ext;
            OP_SUB:   w_alu_result = w_a_ext - w_b_ext;
            // Operands are already 2*DATA_W wide, so the truncated product is exact.
            OP_MULT:  w_alu_result = w_a_ext * w_b_ext;
            OP_DIV: begin
                if (w_b_ext == '0) begin
                    w_alu_err = 1'b1;
                end else begin
                    w_alu_result = w_a_ext / w_b_ext;
                end
            end
            OP_MOD: begin
                if (w_b_ext == '0) begin
                    w_alu_err = 1'b1;
                end else begin
                    w_alu_result = w_a_ext % w_b_ext;
                end
            end
            default: begin
                w_alu_result = '0;
                w_alu_err    = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output register: loads from stage E, holds while stalled
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_en) begin
        if (!reset_en) begin
            r_res_valid <= 1'b0;
            r_res_index <= '0;
            r_res_opc   <= '0;
            r_result    <= '0;
            r_res_err   <= 1'b0;
        end else if (w_e_adv) begin
            r_res_valid <= 1'b1;
            r_res_index <= r_e_idx;
            r_res_opc   <= r_e_opc;
            r_result    <= w_alu_result;
            r_res_err   <= w_alu_err;
        end else if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy       = r_busy;
    assign done       = r_done;
    assign read_index = r_read_index;
    assign res_valid  = r_res_valid;
    assign res_index  = r_res_index;
    assign res_opc    = r_res_opc;
    assign result     = r_result;
    assign res_err    = r_res_err;

endmodule

// File: tb/tb_instr_exec_unit.sv
// ============================================================================
// tb_instr_exec_unit
//
// Directed testbench for instr_exec_unit (DEPTH=32, DATA_W=32). The bench
// models the instruction register as arrays read combinationally through
// read_index. Inputs change and outputs are sampled 1 time unit after each
// rising clock edge.
// ============================================================================
module tb_instr_exec_unit;

    localparam int DEPTH  = 32;
    localparam int DATA_W = 32;
    localparam int IDX_W  = $clog2(DEPTH);

    localparam logic [2:0] OP_ZERO  = 3'd0;
    localparam logic [2:0] OP_PASSA = 3'd1;
    localparam logic [2:0] OP_PASSB = 3'd2;
    localparam logic [2:0] OP_ADD   = 3'd3;
    localparam logic [2:0] OP_SUB   = 3'd4;
    localparam logic [2:0] OP_MULT  = 3'd5;
    localparam logic [2:0] OP_DIV   = 3'd6;
    localparam logic [2:0] OP_MOD   = 3'd7;

    logic                  clk;
    logic                  reset_en;
    logic                  start;
    logic [IDX_W:0]        count;
    logic                  busy;
    logic                  done;
    logic [IDX_W-1:0]      read_index;
    logic [2:0]            opcode;
    logic [DATA_W-1:0]     operand_a;
    logic [DATA_W-1:0]     operand_b;
    logic                  res_valid;
    logic                  res_ready;
    logic [IDX_W-1:0]      res_index;
    logic [2:0]            res_opc;
    logic [2*DATA_W-1:0]   result;
    logic                  res_err;

    // Instruction register model
    logic [2:0]        mem_opc [DEPTH];
    logic [DATA_W-1:0] mem_a   [DEPTH];
    logic [DATA_W-1:0] mem_b   [DEPTH];

    assign opcode    = mem_opc[read_index];
    assign operand_a = mem_a[read_index];
    assign operand_b = mem_b[read_index];

    // Expected result stream for run_expect
    logic [63:0] exp_res [64];
    logic        exp_err [64];
    logic [2:0]  exp_opc [64];

    // Per-cycle expectations for the stalled run (edges k+3 .. k+12)
    int     t_valid [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int     t_idx   [10] = '{1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    longint t_res   [10] = '{0, 0, 0, -7, -7, -7, 10000, 10000, 10000, 0};
    int     t_err   [10] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    int     t_done  [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

    int n_cmp = 0;
    int n_err = 0;

    instr_exec_unit #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk        (clk),
        .reset_en   (reset_en),
        .start      (start),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .read_index (read_index),
        .opcode     (opcode),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_index  (res_index),
        .res_opc    (res_opc),
        .result     (result),
        .res_err    (res_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int i, input logic [2:0] o,
                        input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        mem_opc[i] = o;
        mem_a[i]   = a;
        mem_b[i]   = b;
    endtask

    task automatic load_basic();
        load(0, OP_ADD,  32'd5,   32'd7);
        load(1, OP_DIV,  32'd10,  32'd0);
        load(2, OP_SUB,  32'd3,   32'd10);
        load(3, OP_MULT, 32'd100, 32'd100);
        exp_res[0] = 64'd12;     exp_err[0] = 1'b0; exp_opc[0] = OP_ADD;
        exp_res[1] = 64'd0;      exp_err[1] = 1'b1; exp_opc[1] = OP_DIV;
        exp_res[2] = -64'sd7;    exp_err[2] = 1'b0; exp_opc[2] = OP_SUB;
        exp_res[3] = 64'd10000;  exp_err[3] = 1'b0; exp_opc[3] = OP_MULT;
    endtask

    // Start a run with res_ready=1 and check the streamed results against
    // exp_*. restart_at >= 0 pulses start (count=1) that many cycles into the run.
    task automatic run_expect(input int cnt, input int n_exp, input int restart_at);
        int n;
        bit got_done;
        n        = 0;
        got_done = 1'b0;
        res_ready = 1'b1;
        start     = 1'b1;
        count     = (IDX_W+1)'(cnt);
        tick();
        start = 1'b0;
        check("busy_on_start", busy, 1);
        check("rdidx_on_start", read_index, 0);
        for (int c = 0; c < 200 && !got_done; c++) begin
            if (c == restart_at) begin
                start = 1'b1;
                count = 1;
            end
            tick();
            start = 1'b0;
            if (res_valid) begin
                check($sformatf("res_index[%0d]", n), res_index, n);
                if (n < 64) begin
                    check($sformatf("result[%0d]", n), result, exp_res[n]);
                    check($sformatf("res_err[%0d]", n), res_err, exp_err[n]);
                    check($sformatf("res_opc[%0d]", n), res_opc, exp_opc[n]);
                end
                n++;
            end
            if (done) got_done = 1'b1;
        end
        check("done_seen", got_done, 1);
        check("result_count", n, n_exp);
        check("busy_after_run", busy, 0);
        tick();
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        reset_en  = 1'b0;
        start     = 1'b0;
        count     = '0;
        res_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) load(i, OP_ZERO, '0, '0);

        // ---------------- reset state ----------------
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_read_index", read_index, 0);
        check("rst_result", result, 0);
        tick();
        tick();
        reset_en = 1'b1;
        tick();

        // ---------------- basic run, res_ready=1 ----------------
        load_basic();
        start = 1'b1;
        count = 4;
        tick();                                   // edge k
        start = 1'b0;
        check("t1_busy_k", busy, 1);
        check("t1_rdidx_k", read_index, 0);
        tick();                                   // edge k+1
        check("t1_valid_k1", res_valid, 0);
        check("t1_rdidx_k1", read_index, 1);
        tick();                                   // edge k+2
        check("t1_valid_k2", res_valid, 1);
        check("t1_idx_k2", res_index, 0);
        check("t1_res_k2", result, 64'd12);
        check("t1_err_k2", res_err, 0);
        check("t1_opc_k2", res_opc, OP_ADD);
        tick();
        check("t1_idx_k3", res_index, 1);
        check("t1_res_k3", result, 64'd0);
        check("t1_err_k3", res_err, 1);
        tick();
        check("t1_idx_k4", res_index, 2);
        check("t1_res_k4", result, -64'sd7);
        check("t1_err_k4", res_err, 0);
        tick();
        check("t1_idx_k5", res_index, 3);
        check("t1_res_k5", result, 64'd10000);
        check("t1_done_k5", done, 0);
        tick();
        check("t1_valid_k6", res_valid, 0);
        check("t1_done_k6", done, 1);
        check("t1_busy_k6", busy, 0);
        tick();
        check("t1_done_k7", done, 0);

        // ---------------- stalled run, res_ready 1,0,0,... ----------------
        start = 1'b1;
        count = 4;
        tick();                                   // edge k
        start = 1'b0;
        tick();                                   // edge k+1
        tick();                                   // edge k+2
        check("t2_valid_k2", res_valid, 1);
        check("t2_idx_k2", res_index, 0);
        check("t2_res_k2", result, 64'd12);
        check("t2_rdidx_k2", read_index, 2);
        for (int j = 0; j < 10; j++) begin
            res_ready = (j % 3 == 0);
            tick();
            check($sformatf("t2_valid[%0d]", j), res_valid, t_valid[j]);
            check($sformatf("t2_done[%0d]", j), done, t_done[j]);
            check($sformatf("t2_rdidx[%0d]", j), read_index, (j < 3) ? 3 : 4);
            if (t_valid[j] != 0) begin
                check($sformatf("t2_idx[%0d]", j), res_index, t_idx[j]);
                check($sformatf("t2_res[%0d]", j), result, t_res[j]);
                check($sformatf("t2_err[%0d]", j), res_err, t_err[j]);
            end
        end
        check("t2_busy_end", busy, 0);
        res_ready = 1'b1;
        tick();

        // ---------------- count = 0 ----------------
        start = 1'b1;
        count = 0;
        tick();
        start = 1'b0;
        check("c0_done", done, 1);
        check("c0_busy", busy, 0);
        check("c0_valid", res_valid, 0);
        tick();
        check("c0_done_drop", done, 0);
        check("c0_busy2", busy, 0);
        check("c0_valid2", res_valid, 0);
        tick();

        // ---------------- count = DEPTH+5 (clamped) ----------------
        for (int i = 0; i < DEPTH; i++) begin
            load(i, OP_PASSA, DATA_W'(i * 3 + 1), 32'd99);
            exp_res[i] = 64'(i * 3 + 1);
            exp_err[i] = 1'b0;
            exp_opc[i] = OP_PASSA;
        end
        run_expect(DEPTH + 5, DEPTH, -1);
        check("clamp_rdidx_wrap", read_index, 0);

        // ---------------- operator corner cases ----------------
        load(0, OP_MOD,   -32'sd7, 32'sd2);
        load(1, OP_DIV,   -32'sd7, 32'sd2);
        load(2, OP_PASSA, -32'sd1, 32'sd5);
        load(3, OP_ZERO,  32'sd9,  32'sd9);
        load(4, OP_PASSB, 32'sd3,  -32'sd4);
        load(5, OP_MULT,  -32'sd3, 32'h7FFF_FFFF);
        load(6, OP_MOD,   32'sd7,  -32'sd2);
        load(7, OP_MOD,   32'sd5,  32'sd0);
        exp_res[0] = -64'sd1;               exp_err[0] = 1'b0; exp_opc[0] = OP_MOD;
        exp_res[1] = -64'sd3;               exp_err[1] = 1'b0; exp_opc[1] = OP_DIV;
        exp_res[2] = 64'hFFFF_FFFF_FFFF_FFFF; exp_err[2] = 1'b0; exp_opc[2] = OP_PASSA;
        exp_res[3] = 64'd0;                 exp_err[3] = 1'b0; exp_opc[3] = OP_ZERO;
        exp_res[4] = -64'sd4;               exp_err[4] = 1'b0; exp_opc[4] = OP_PASSB;
        exp_res[5] = 64'hFFFF_FFFE_8000_0003; exp_err[5] = 1'b0; exp_opc[5] = OP_MULT;
        exp_res[6] = 64'd1;                 exp_err[6] = 1'b0; exp_opc[6] = OP_MOD;
        exp_res[7] = 64'd0;                 exp_err[7] = 1'b1; exp_opc[7] = OP_MOD;
        run_expect(8, 8, -1);

        // ---------------- start while busy is ignored ----------------
        load_basic();
        run_expect(4, 4, 1);

        // ---------------- reset mid-run, then restart ----------------
        load_basic();
        res_ready = 1'b1;
        start = 1'b1;
        count = 4;
        tick();                                   // edge k
        start = 1'b0;
        tick();                                   // k+1
        tick();                                   // k+2: index 0 shown
        tick();                                   // k+3: index 1 shown
        tick();                                   // k+4: 2 delivered, index 2 shown
        check("mr_pre_idx", res_index, 2);
        check("mr_pre_res", result, -64'sd7);
        #2;
        reset_en = 1'b0;
        #1;
        check("mr_busy", busy, 0);
        check("mr_done", done, 0);
        check("mr_valid", res_valid, 0);
        check("mr_err", res_err, 0);
        check("mr_rdidx", read_index, 0);
        check("mr_res_index", res_index, 0);
        check("mr_res_opc", res_opc, 0);
        check("mr_result", result, 0);
        tick();
        tick();
        check("mr_hold_valid", res_valid, 0);
        reset_en = 1'b1;
        run_expect(2, 2, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
